// File: rtl/aes_128_core_arbiter.sv
// Round-robin arbiter/sequencer sharing one iterative AES-128 core among
// NUM_REQ requesters. A single job is in flight at a time: grant, start the
// core, wait for completion (or give up after TIMEOUT cycles), then hand the
// ciphertext back to the owner over a valid/ready response channel.
module aes_128_core_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    input  logic [NUM_REQ*128-1:0]     req_pt_i,
    input  logic [NUM_REQ*128-1:0]     req_key_i,
    output logic                       core_start_o,
    output logic [127:0]               core_pt_o,
    output logic [127:0]               core_key_o,
    input  logic                       core_done_i,
    input  logic [127:0]               core_ct_i,
    output logic [NUM_REQ-1:0]         rsp_valid_o,
    input  logic [NUM_REQ-1:0]         rsp_ready_i,
    output logic [127:0]               rsp_ct_o,
    output logic                       rsp_err_o,
    output logic                       busy_o,
    output logic [$clog2(NUM_REQ)-1:0] owner_o
);

    localparam int IW = $clog2(NUM_REQ);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // The counter starts at 0 in the first WAIT cycle; the job is abandoned
    // in the cycle where its incremented value would reach TIMEOUT-1, so RESP
    // is entered exactly TIMEOUT cycles after the ISSUE cycle.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 2);

    logic [1:0]    state_reg;
    logic [IW-1:0] rr_ptr_reg;
    logic [IW-1:0] owner_reg;
    logic [127:0]  pt_reg;
    logic [127:0]  key_reg;
    logic [127:0]  ct_reg;
    logic          err_reg;
    logic [7:0]    cnt_reg;

    // Candidate list in round-robin order: slot gi holds requester
    // (rr_ptr + gi) mod NUM_REQ, so slot 0 has the highest priority.
    logic [IW:0]        cand_sum [NUM_REQ];
    logic [IW-1:0]      cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] cand_valid;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        assign cand_sum[gi]   = {1'b0, rr_ptr_reg} + (IW+1)'(gi);
        assign cand_idx[gi]   = (cand_sum[gi] >= (IW+1)'(NUM_REQ))
                              ? IW'(cand_sum[gi] - (IW+1)'(NUM_REQ))
                              : cand_sum[gi][IW-1:0];
        assign cand_valid[gi] = req_valid_i[cand_idx[gi]];
    end

    logic [IW-1:0] win_idx;
    logic          win_found;

    // Pick the first valid candidate; scanning downward lets slot 0 win last.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (cand_valid[i]) begin
                win_found = 1'b1;
                win_idx   = cand_idx[i];
            end
        end
    end

    // Job sequencing: grant/latch, start, wait for done or timeout, respond.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg  <= ST_IDLE;
            rr_ptr_reg <= '0;
            owner_reg  <= '0;
            pt_reg     <= '0;
            key_reg    <= '0;
            ct_reg     <= '0;
            err_reg    <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (win_found) begin
                        pt_reg    <= req_pt_i[int'(win_idx) * 128 +: 128];
                        key_reg   <= req_key_i[int'(win_idx) * 128 +: 128];
                        owner_reg <= win_idx;
                        state_reg <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cnt_reg   <= '0;
                    state_reg <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Completion takes precedence over a coincident timeout.
                    if (core_done_i) begin
                        ct_reg    <= core_ct_i;
                        err_reg   <= 1'b0;
                        state_reg <= ST_RESP;
                    end else if (cnt_reg == CNT_LAST) begin
                        ct_reg    <= '0;
                        err_reg   <= 1'b1;
                        state_reg <= ST_RESP;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                default: begin
                    if (rsp_ready_i[owner_reg]) begin
                        rr_ptr_reg <= (owner_reg == IW'(NUM_REQ - 1)) ? '0 : owner_reg + 1'b1;
                        state_reg  <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
        assign req_ready_o[gi] = (state_reg == ST_IDLE) && win_found && (win_idx == IW'(gi));
        assign rsp_valid_o[gi] = (state_reg == ST_RESP) && (owner_reg == IW'(gi));
    end

    assign core_start_o = (state_reg == ST_ISSUE);
    assign core_pt_o    = pt_reg;
    assign core_key_o   = key_reg;
    assign rsp_ct_o     = (state_reg == ST_RESP) ? ct_reg : '0;
    assign rsp_err_o    = (state_reg == ST_RESP) && err_reg;
    assign busy_o       = (state_reg != ST_IDLE);
    assign owner_o      = owner_reg;

endmodule

// File: tb/tb_aes_128_core_arbiter.sv
// Directed bench for aes_128_core_arbiter with a behavioural AES core stub
// whose latency, enable and returned ciphertext are set per step.
module tb_aes_128_core_arbiter;

    localparam int NR = 4;
    localparam int TO = 32;

    localparam logic [127:0] PT0  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT0  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT1  = 128'h11111111222222223333333344444444;
    localparam logic [127:0] CT1  = 128'hdeadbeef0123456789abcdeffedcba98;
    localparam logic [127:0] PT2  = 128'hcafef00dcafef00dcafef00dcafef00d;
    localparam logic [127:0] CT2  = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    localparam logic [127:0] PT3  = 128'h33333333333333333333333333333333;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
    logic [NR*128-1:0] req_pt, req_key;
    logic              core_start, core_done, rsp_err, busy;
    logic [127:0]      core_pt, core_key, core_ct, rsp_ct;
    logic [1:0]        owner;

    int n_cmp = 0;
    int n_err = 0;
    int n_start = 0;
    int cyc = 0;

    int           lat = 3;
    bit           core_en = 1'b1;
    bit           stray_done = 1'b0;
    int           cd = 0;
    logic [127:0] stub_ct = '0;

    aes_128_core_arbiter #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_pt_i(req_pt), .req_key_i(req_key),
        .core_start_o(core_start), .core_pt_o(core_pt), .core_key_o(core_key),
        .core_done_i(core_done), .core_ct_i(core_ct),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_ct_o(rsp_ct), .rsp_err_o(rsp_err),
        .busy_o(busy), .owner_o(owner)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (core_start) n_start <= n_start + 1;
    end

    // Core stub: done pulses 'lat' cycles after the start cycle.
    always @(posedge clk) begin
        if (core_start && core_en) cd <= lat;
        else if (cd > 0)           cd <= cd - 1;
    end
    assign core_done = (cd == 1) || stray_done;
    assign core_ct   = stub_ct;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_grant();
        int n = 0;
        #1;
        while (req_ready === '0 && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_rsp(output int k);
        k = 0;
        while (rsp_valid === '0 && k < 60) begin
            @(negedge clk);
            k++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int prev_cyc;
        rst_n = 1'b0; req_valid = '0; req_pt = '0; req_key = '0; rsp_ready = '0;
        step(2);
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_start", core_start, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_owner", owner, 0);
        chk("rst_core_pt", core_pt, 0);
        chk("rst_rsp_ct", rsp_ct, 0);
        chk("rst_err", rsp_err, 0);
        rst_n = 1'b1;
        step(1);

        // Single job from requester 2, core latency 10.
        lat = 10; stub_ct = CT0;
        req_pt[2*128 +: 128] = PT0; req_key[2*128 +: 128] = KEY0;
        req_valid = 4'b0100;
        #1;
        chk("t1_ready", req_ready, 4'b0100);
        step(1);
        req_valid = '0;
        chk("t1_start", core_start, 1);
        chk("t1_core_pt", core_pt, PT0);
        chk("t1_core_key", core_key, KEY0);
        chk("t1_owner", owner, 2);
        chk("t1_ready_issue", req_ready, 0);
        wait_rsp(k);
        chk("t1_latency", k, 11);
        chk("t1_rsp_valid", rsp_valid, 4'b0100);
        chk("t1_rsp_ct", rsp_ct, CT0);
        chk("t1_rsp_err", rsp_err, 0);
        rsp_ready = 4'b0100;
        step(1);
        rsp_ready = '0;
        chk("t1_busy_after", busy, 0);
        chk("t1_rsp_valid_after", rsp_valid, 0);
        chk("t1_start_count", n_start, 1);

        // Fairness: reset the pointer, all requesters busy, core latency 3.
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        lat = 3; stub_ct = CT1; rsp_ready = 4'b1111;
        for (int r = 0; r < NR; r++) begin
            req_pt[r*128 +: 128]  = {32'(r), 96'h5a5a};
            req_key[r*128 +: 128] = {96'h0, 32'(r)};
        end
        req_valid = 4'b1111;
        prev_cyc = 0;
        for (int j = 0; j < 8; j++) begin
            wait_grant();
            chk($sformatf("fair_grant%0d", j), req_ready, 4'b0001 << (j % 4));
            if (j > 0) chk($sformatf("fair_period%0d", j), cyc - prev_cyc, 6);
            prev_cyc = cyc;
            step(1);
        end
        req_valid = '0;
        step(6);
        chk("fair_idle", busy, 0);
        chk("fair_start_count", n_start, 9);

        // Backpressure on requester 1; requester 0 ready must be ignored.
        rsp_ready = 4'b0001; lat = 2; stub_ct = CT1;
        req_pt[1*128 +: 128] = PT1;
        req_valid = 4'b0010;
        wait_grant();
        chk("bp_grant", req_ready, 4'b0010);
        step(1);
        req_valid = 4'b1101;
        wait_rsp(k);
        chk("bp_latency", k, 3);
        stub_ct = '1;
        for (int i = 0; i < 20; i++) begin
            stray_done = (i == 5);
            chk($sformatf("bp_valid%0d", i), rsp_valid, 4'b0010);
            chk($sformatf("bp_ct%0d", i), rsp_ct, CT1);
            chk($sformatf("bp_ready%0d", i), req_ready, 0);
            step(1);
        end
        stray_done = 1'b0;
        rsp_ready = 4'b0010;
        step(1);
        chk("bp_busy_after", busy, 0);
        chk("bp_rr_next", req_ready, 4'b0100);
        req_valid = '0; rsp_ready = '0;

        // Timeout: core never completes.
        core_en = 1'b0;
        req_pt[3*128 +: 128] = PT3;
        req_valid = 4'b1000;
        #1;
        chk("to_grant", req_ready, 4'b1000);
        step(1);
        req_valid = '0;
        chk("to_start", core_start, 1);
        wait_rsp(k);
        chk("to_latency", k, 32);
        chk("to_rsp_valid", rsp_valid, 4'b1000);
        chk("to_rsp_err", rsp_err, 1);
        chk("to_rsp_ct", rsp_ct, 0);
        rsp_ready = 4'b1000;
        step(1);
        rsp_ready = '0;
        req_valid = 4'b1111;
        #1;
        chk("to_rr_wrap", req_ready, 4'b0001);
        req_valid = '0;
        core_en = 1'b1;

        // Stray done in IDLE and ISSUE; real done on the timeout cycle.
        stray_done = 1'b1;
        step(1);
        stray_done = 1'b0;
        chk("race_idle_busy", busy, 0);
        chk("race_idle_rsp", rsp_valid, 0);
        lat = 31; stub_ct = CT2;
        req_pt[0] = 1'b0;
        req_pt[0*128 +: 128] = PT2;
        req_valid = 4'b0001;
        #1;
        chk("race_grant", req_ready, 4'b0001);
        step(1);
        req_valid = '0;
        stray_done = 1'b1;
        chk("race_start", core_start, 1);
        step(1);
        stray_done = 1'b0;
        chk("race_wait_busy", busy, 1);
        chk("race_wait_rsp", rsp_valid, 0);
        chk("race_core_pt", core_pt, PT2);
        wait_rsp(k);
        chk("race_latency", k, 31);
        chk("race_err", rsp_err, 0);
        chk("race_ct", rsp_ct, CT2);
        chk("race_valid", rsp_valid, 4'b0001);
        rsp_ready = 4'b0001;
        step(1);
        rsp_ready = '0;

        // Reset in the middle of WAIT.
        lat = 20;
        req_valid = 4'b0100;
        #1;
        chk("rm_grant", req_ready, 4'b0100);
        step(1);
        req_valid = '0;
        step(3);
        rst_n = 1'b0;
        #1;
        chk("rm_busy", busy, 0);
        chk("rm_owner", owner, 0);
        chk("rm_core_pt", core_pt, 0);
        chk("rm_core_key", core_key, 0);
        chk("rm_rsp_valid", rsp_valid, 0);
        chk("rm_start", core_start, 0);
        step(1);
        rst_n = 1'b1;
        lat = 1; stub_ct = CT1;
        req_valid = 4'b1010;
        #1;
        chk("rm_lowest", req_ready, 4'b0010);
        step(1);
        req_valid = '0;
        chk("rm_core_pt_new", core_pt, PT1);
        wait_rsp(k);
        chk("rm_latency", k, 2);
        chk("rm_rsp_ct", rsp_ct, CT1);
        chk("rm_rsp_valid_new", rsp_valid, 4'b0010);
        rsp_ready = 4'b0010;
        step(1);
        rsp_ready = '0;
        chk("rm_busy_after", busy, 0);
        chk("total_starts", n_start, 14);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/aes_128_core_arbiter.md
Name: aes_128_core_arbiter

Overview:
Round-robin arbiter and sequencer that shares one iterative AES-128 encryption core among NUM_REQ requesters.
- Accepts one plaintext/key job at a time and launches it on the core.
- Waits for the core's completion pulse, then returns the ciphertext to the owning requester over a valid/ready response channel.
- Sits between the request ports and the single AES core instance; it is the only block that drives the core's start inputs.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..8.
TIMEOUT, 32, max cycles in WAIT before the job is aborted; legal range 12..255.

Ports:
clk_i  in  1  clock, rising edge.
rst_ni  in  1  reset, asynchronous, active-low.
req_valid_i  in  NUM_REQ  per-requester job request.
req_ready_o  out  NUM_REQ  one-hot accept; job transfers when valid and ready are both high.
req_pt_i  in  NUM_REQ*128  plaintexts; requester k uses bits [128k+127:128k].
req_key_i  in  NUM_REQ*128  keys, packed the same way.
core_start_o  out  1  one-cycle start pulse to the AES core.
core_pt_o  out  128  plaintext to the core; held stable from ISSUE until the job completes.
core_key_o  out  128  key to the core; held stable the same way.
core_done_i  in  1  core completion pulse.
core_ct_i  in  128  ciphertext, valid while core_done_i is high.
rsp_valid_o  out  NUM_REQ  one-hot response valid.
rsp_ready_i  in  NUM_REQ  per-requester response ready.
rsp_ct_o  out  128  response ciphertext, shared by all requesters.
rsp_err_o  out  1  high with rsp_valid_o when the job timed out; rsp_ct_o is 0 in that case.
busy_o  out  1  high in every state except IDLE.
owner_o  out  $clog2(NUM_REQ)  index of the current job owner.

Behaviour:
- Reset (async assert, sync release): state=IDLE, rr_ptr=0, all outputs 0, internal data registers 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Winner = first k with req_valid_i[k]=1, scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - req_ready_o[winner]=1 combinationally in the same cycle; all other ready bits stay 0.
  - On that edge: latch pt/key/owner and go to ISSUE.
  - No valid request: stay in IDLE, req_ready_o=0.
- ISSUE: core_start_o=1 for exactly one cycle, core_pt_o/core_key_o driven from the latched registers, clear the timeout counter, go to WAIT.
- WAIT:
  - core_done_i=1: latch core_ct_i, err=0, go to RESP.
  - Otherwise increment the counter; when counter reaches TIMEOUT-1 with no done: ct=0, err=1, go to RESP.
  - If done and timeout occur in the same cycle, done wins (err=0).
- core_done_i is ignored in IDLE, ISSUE and RESP; a stray pulse must not change state or data.
- RESP:
  - rsp_valid_o[owner]=1; rsp_ct_o and rsp_err_o held stable until rsp_ready_i[owner]=1.
  - On that handshake edge: rr_ptr=(owner+1) mod NUM_REQ, go to IDLE.
  - Ready bits from non-owners are ignored.
- req_ready_o=0 in every state except IDLE. A new job is accepted no earlier than the cycle after the response handshake.
- Minimum turnaround: accept(IDLE) → ISSUE → WAIT(done in its first cycle) → RESP(ready already high) = 4 cycles per job.
- Requesters may drop req_valid_i before they are granted; the arbiter holds no state for ungranted requests.
- Reset asserted mid-job: abort immediately with no response emitted; after release, rr_ptr=0.

Test Plan:
- Single job: requester 2 sends pt=00112233445566778899aabbccddeeff, key=000102030405060708090a0b0c0d0e0f; core stub returns ct=69c4e0d86a7b0430d8cdb78070b4c55a after 10 cycles. Required: exactly one core_start_o pulse; rsp_valid_o=4'b0100 with that ct and rsp_err_o=0; busy_o=0 after the handshake.
- Fairness: all four req_valid_i held high for 8 jobs, core latency 3. Required: grant order 0,1,2,3,0,1,2,3; every job takes 6 cycles from accept to handshake.
- Backpressure: rsp_ready_i[1] held low for 20 cycles. Required: rsp_valid_o[1] and rsp_ct_o stable throughout; req_ready_o=0 for all requesters; rsp_ready_i[0]=1 during the stall has no effect.
- Timeout: core_done_i never asserted, TIMEOUT=32. Required: RESP entered exactly 32 cycles after the ISSUE cycle, with rsp_err_o=1 and rsp_ct_o=0; rr_ptr advances normally.
- Races: core_done_i pulsed in IDLE and in ISSUE. Required: both pulses ignored. core_done_i arriving in the same cycle the counter hits TIMEOUT-1 gives err=0 and the captured ct.
- Reset mid-WAIT: assert rst_ni low for 1 cycle. Required: all outputs go to 0 asynchronously; after release, the next grant goes to the lowest valid index.
